// File: rtl/caesar_pkg.sv
// Shared Caesar constants and letter-rotation arithmetic, common to the
// encrypt and decrypt sides of the link.
package caesar_pkg;

    localparam int         ALPHA_LEN = 26;
    localparam logic [7:0] UPPER_A   = 8'h41;
    localparam logic [7:0] UPPER_Z   = 8'h5A;
    localparam logic [7:0] LOWER_A   = 8'h61;
    localparam logic [7:0] LOWER_Z   = 8'h7A;

    // Rotates letters by key within their own case; non-letters pass through.
    // key must already be below ALPHA_LEN.
    function automatic logic [7:0] alpha_shift(
        input logic [7:0] c,
        input logic [7:0] key,
        input logic       decrypt
    );
        logic       in_upper;
        logic       in_lower;
        logic [7:0] base;
        logic [8:0] off;
        logic [8:0] r;
        logic [7:0] result;

        in_upper = (c >= UPPER_A) && (c <= UPPER_Z);
        in_lower = (c >= LOWER_A) && (c <= LOWER_Z);
        if (in_upper) begin
            base = UPPER_A;
        end else begin
            base = LOWER_A;
        end
        off = {1'b0, c - base};

        if (decrypt) begin
            r = off - {1'b0, key};
            if (r[8]) begin
                r = r + 9'(ALPHA_LEN);
            end else begin
                r = r;
            end
        end else begin
            r = off + {1'b0, key};
            if (r >= 9'(ALPHA_LEN)) begin
                r = r - 9'(ALPHA_LEN);
            end else begin
                r = r;
            end
        end

        if (in_upper || in_lower) begin
            result = base + r[7:0];
        end else begin
            result = c;
        end
        return result;
    endfunction

endpackage

// File: rtl/caesar_decipher_stream_if.sv
// Single-direction ready/valid byte stream; the producer uses master, the
// consumer uses slave.
interface caesar_decipher_stream_if #(
    parameter int N = 8
);
    logic [N-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/caesar_sub_core.sv
// Combinational per-byte decryption: modular subtract, or backward letter
// rotation when ALPHA_MODE is 1 (8-bit data only).
module caesar_sub_core
    import caesar_pkg::*;
#(
    parameter int N          = 8,
    parameter int ALPHA_MODE = 0
) (
    input  logic [N-1:0] i_cipher,
    input  logic [N-1:0] i_key,
    output logic [N-1:0] o_plain
);

    generate
        if (ALPHA_MODE == 1) begin : g_alpha
            assign o_plain = N'(alpha_shift(8'(i_cipher), 8'(i_key), 1'b1));
        end else begin : g_mod
            // Borrow falls off the top, giving the mod 2^N result.
            assign o_plain = i_cipher - i_key;
        end
    endgenerate

endmodule

// File: rtl/caesar_decipher_stream.sv
// Streaming Caesar decryptor: per-stream key register, ready/valid in and
// out, two-entry output buffer and a delivered-byte counter.
module caesar_decipher_stream
    import caesar_pkg::*;
#(
    parameter int N          = 8,
    parameter int ALPHA_MODE = 0,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             key_in,
    input  logic                     key_load,
    output logic                     key_valid,
    output logic                     key_err,
    caesar_decipher_stream_if.slave  s_if,
    caesar_decipher_stream_if.master m_if,
    output logic [CNT_W-1:0]         byte_cnt
);

    localparam logic [0:0] ST_NOKEY = 1'b0;
    localparam logic [0:0] ST_KEYED = 1'b1;

    logic [0:0]       r_state;
    logic [N-1:0]     r_key;
    logic             r_key_err;
    logic [N-1:0]     r_head;
    logic [N-1:0]     r_tail;
    logic [1:0]       r_fill;
    logic [CNT_W-1:0] r_byte_cnt;

    logic [0:0]       w_state_next;
    logic             w_key_legal;
    logic [N-1:0]     w_plain;
    logic             w_push;
    logic             w_pop;

    caesar_sub_core #(
        .N          (N),
        .ALPHA_MODE (ALPHA_MODE)
    ) u_core (
        .i_cipher (s_if.data),
        .i_key    (r_key),
        .o_plain  (w_plain)
    );

    assign key_valid  = (r_state == ST_KEYED);
    assign key_err    = r_key_err;
    assign byte_cnt   = r_byte_cnt;
    assign s_if.ready = (r_state == ST_KEYED) && (r_fill < 2'd2);
    assign m_if.valid = (r_fill != 2'd0);
    assign m_if.data  = r_head;

    assign w_push = s_if.valid && s_if.ready;
    assign w_pop  = m_if.valid && m_if.ready;

    // Letter mode only accepts shifts that stay inside the alphabet.
    always_comb begin
        if (ALPHA_MODE == 1) begin
            w_key_legal = (key_in < N'(ALPHA_LEN));
        end else begin
            w_key_legal = 1'b1;
        end
    end

    // Key state: only reset leaves KEYED.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_NOKEY: begin
                if (key_load && w_key_legal) begin
                    w_state_next = ST_KEYED;
                end else begin
                    w_state_next = ST_NOKEY;
                end
            end
            ST_KEYED: w_state_next = ST_KEYED;
            default:  w_state_next = ST_NOKEY;
        endcase
    end

    // Key register, state and sticky rejection flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_NOKEY;
            r_key     <= {N{1'b0}};
            r_key_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (key_load) begin
                if (w_key_legal) begin
                    r_key     <= key_in;
                    r_key_err <= 1'b0;
                end else begin
                    r_key_err <= 1'b1;
                end
            end else begin
                r_key_err <= r_key_err;
            end
        end
    end

    // Two-entry output buffer; a push is never offered while full because
    // s_ready is low then.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= {N{1'b0}};
            r_tail <= {N{1'b0}};
            r_fill <= 2'd0;
        end else begin
            case (r_fill)
                2'd0: begin
                    if (w_push) begin
                        r_head <= w_plain;
                        r_fill <= 2'd1;
                    end else begin
                        r_fill <= 2'd0;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= w_plain;
                    end else if (w_push) begin
                        r_tail <= w_plain;
                        r_fill <= 2'd2;
                    end else if (w_pop) begin
                        r_fill <= 2'd0;
                    end else begin
                        r_fill <= 2'd1;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_fill <= 2'd1;
                    end else begin
                        r_fill <= 2'd2;
                    end
                end
                default: r_fill <= 2'd0;
            endcase
        end
    end

    // Delivered-byte counter; any key_load clears it, even on a pop cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= {CNT_W{1'b0}};
        end else if (key_load) begin
            r_byte_cnt <= {CNT_W{1'b0}};
        end else if (w_pop) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end else begin
            r_byte_cnt <= r_byte_cnt;
        end
    end

endmodule

// File: tb/tb_caesar_decipher_stream.sv
// Directed bench: one DUT per ALPHA_MODE, a vector table plus hand-written
// sequences for back-pressure, key change and reset.
module tb_caesar_decipher_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  key_in;
    logic [7:0]  s_data;
    logic        m_ready;
    logic        kl0, kl1, sv0, sv1;
    logic        kv0, kv1, ke0, ke1;
    logic [15:0] cnt0, cnt1;
    logic        sel;

    logic [7:0]  o_mdata;
    logic        o_mvalid, o_sready, o_kv, o_ke;
    logic [15:0] o_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    caesar_decipher_stream_if #(.N(8)) s0_if ();
    caesar_decipher_stream_if #(.N(8)) m0_if ();
    caesar_decipher_stream_if #(.N(8)) s1_if ();
    caesar_decipher_stream_if #(.N(8)) m1_if ();

    assign s0_if.data  = s_data;
    assign s0_if.valid = sv0;
    assign m0_if.ready = m_ready;
    assign s1_if.data  = s_data;
    assign s1_if.valid = sv1;
    assign m1_if.ready = m_ready;

    caesar_decipher_stream #(.N(8), .ALPHA_MODE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(kl0),
        .key_valid(kv0), .key_err(ke0), .s_if(s0_if), .m_if(m0_if),
        .byte_cnt(cnt0)
    );

    caesar_decipher_stream #(.N(8), .ALPHA_MODE(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(kl1),
        .key_valid(kv1), .key_err(ke1), .s_if(s1_if), .m_if(m1_if),
        .byte_cnt(cnt1)
    );

    always_comb begin
        if (sel) begin
            o_mdata = m1_if.data; o_mvalid = m1_if.valid; o_sready = s1_if.ready;
            o_kv = kv1; o_ke = ke1; o_cnt = cnt1;
        end else begin
            o_mdata = m0_if.data; o_mvalid = m0_if.valid; o_sready = s0_if.ready;
            o_kv = kv0; o_ke = ke0; o_cnt = cnt0;
        end
    end

    typedef struct {
        bit         mode;
        logic [7:0] key;
        logic [7:0] din;
        logic [7:0] dexp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic en);
        if (sel) kl1 = en; else kl0 = en;
    endtask

    task automatic set_valid(input logic en);
        if (sel) sv1 = en; else sv0 = en;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_in = k;
        set_load(1'b1);
        tick();
        set_load(1'b0);
    endtask

    task automatic send_one(input logic [7:0] d, input logic [7:0] e, input string name);
        s_data  = d;
        m_ready = 1'b1;
        check({name, "_sready"}, o_sready, 1);
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        check({name, "_mdata"}, o_mdata, e);
        check({name, "_mvalid"}, o_mvalid, 1);
        tick();
        check({name, "_drained"}, o_mvalid, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h03, 8'h4B, 8'h48};
        vecs[1]  = '{1'b0, 8'h05, 8'h01, 8'hFC};
        vecs[2]  = '{1'b0, 8'hFF, 8'h00, 8'h01};
        vecs[3]  = '{1'b0, 8'h80, 8'h7F, 8'hFF};
        vecs[4]  = '{1'b1, 8'h03, 8'h62, 8'h79};
        vecs[5]  = '{1'b1, 8'h03, 8'h44, 8'h41};
        vecs[6]  = '{1'b1, 8'h03, 8'h21, 8'h21};
        vecs[7]  = '{1'b1, 8'h01, 8'h41, 8'h5A};
        vecs[8]  = '{1'b1, 8'h0D, 8'h61, 8'h6E};
        vecs[9]  = '{1'b1, 8'h0D, 8'h7A, 8'h6D};
        vecs[10] = '{1'b1, 8'h00, 8'h7B, 8'h7B};
        vecs[11] = '{1'b1, 8'h19, 8'h40, 8'h40};

        rst = 1'b1; key_in = 8'h00; s_data = 8'h00; m_ready = 1'b0;
        kl0 = 1'b0; kl1 = 1'b0; sv0 = 1'b0; sv1 = 1'b0; sel = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state on both instances
        for (int m = 0; m < 2; m++) begin
            sel = m[0];
            #1;
            check("rst_key_valid", o_kv, 0);
            check("rst_key_err", o_ke, 0);
            check("rst_mvalid", o_mvalid, 0);
            check("rst_sready", o_sready, 0);
            check("rst_cnt", o_cnt, 0);
            check("rst_mdata", o_mdata, 0);
        end

        // Basic back-to-back decrypt, mode 0, key 3
        sel = 1'b0;
        load_key(8'h03);
        check("basic_kv", o_kv, 1);
        s_data = 8'h4B; sv0 = 1'b1; m_ready = 1'b1;
        tick();
        check("basic_b0", o_mdata, 8'h48);
        s_data = 8'h68;
        tick();
        check("basic_b1", o_mdata, 8'h65);
        sv0 = 1'b0;
        tick();
        check("basic_empty", o_mvalid, 0);
        check("basic_cnt", o_cnt, 2);

        // Illegal keys in letter mode
        sel = 1'b1;
        load_key(8'd30);
        check("ill_nokey_kv", o_kv, 0);
        check("ill_nokey_err", o_ke, 1);
        check("ill_nokey_sready", o_sready, 0);
        load_key(8'd5);
        check("leg5_err", o_ke, 0);
        check("leg5_kv", o_kv, 1);
        send_one(8'h46, 8'h41, "leg5_F");
        check("leg5_cnt", o_cnt, 1);
        load_key(8'd26);
        check("ill26_err", o_ke, 1);
        check("ill26_kv", o_kv, 1);
        check("ill26_cnt", o_cnt, 0);
        send_one(8'h46, 8'h41, "ill26_oldkey");
        load_key(8'd25);
        check("leg25_err", o_ke, 0);
        send_one(8'h5A, 8'h41, "leg25_Z");

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            sel = vecs[i].mode;
            load_key(vecs[i].key);
            send_one(vecs[i].din, vecs[i].dexp, $sformatf("vec%0d", i));
        end

        // Back-pressure: buffer fills at two, order kept, head stable
        sel = 1'b0;
        load_key(8'h01);
        m_ready = 1'b0;
        s_data = 8'h10; sv0 = 1'b1;
        check("bp_sready0", o_sready, 1);
        tick();
        s_data = 8'h11;
        check("bp_sready1", o_sready, 1);
        tick();
        s_data = 8'h12;
        check("bp_full_sready", o_sready, 0);
        check("bp_hold0", o_mdata, 8'h0F);
        tick();
        check("bp_hold1", o_mdata, 8'h0F);
        check("bp_hold_valid", o_mvalid, 1);
        m_ready = 1'b1;
        tick();
        check("bp_out1", o_mdata, 8'h10);
        tick();
        check("bp_out2", o_mdata, 8'h11);
        sv0 = 1'b0;
        tick();
        check("bp_empty", o_mvalid, 0);
        check("bp_cnt", o_cnt, 3);

        // Key change on an acceptance cycle uses the old key
        s_data = 8'h20; sv0 = 1'b1; key_in = 8'h07; kl0 = 1'b1;
        tick();
        kl0 = 1'b0;
        check("kc_oldkey", o_mdata, 8'h1F);
        check("kc_cnt_clr", o_cnt, 0);
        tick();
        check("kc_newkey", o_mdata, 8'h19);
        check("kc_cnt1", o_cnt, 1);
        sv0 = 1'b0; kl0 = 1'b1;
        tick();
        kl0 = 1'b0;
        check("kc_clear_wins", o_cnt, 0);
        check("kc_empty", o_mvalid, 0);

        // Reset with two bytes buffered
        s_data = 8'h30; sv0 = 1'b1; m_ready = 1'b1;
        tick();
        s_data = 8'h31;
        tick();
        s_data = 8'h32; m_ready = 1'b0;
        tick();
        sv0 = 1'b0;
        check("mr_full", o_sready, 0);
        check("mr_cnt_pre", o_cnt, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_mvalid", o_mvalid, 0);
        check("mr_sready", o_sready, 0);
        check("mr_kv", o_kv, 0);
        check("mr_cnt", o_cnt, 0);
        check("mr_mdata", o_mdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/caesar_decipher_stream.md
Name: caesar_decipher_stream

Overview:
- Streaming Caesar decryptor; the receive-side counterpart of the team's combinational N-bit Caesar encryptor (ciphertext = plaintext + key).
- Recovers plaintext = ciphertext − key, per byte, with a per-stream key register.
- Ready/valid handshake on the input and output sides, plus a 2-entry output buffer so back-pressure never drops data.
- Sits between the UART/byte-stream receive path and the plaintext consumer.

Parameters:
- N, 8: data and key width in bits.
- ALPHA_MODE, 0: 0 = subtract modulo 2^N on every byte; 1 = rotate letters A–Z and a–z backward modulo 26, all other bytes pass through unchanged (requires N=8).
- CNT_W, 16: width of the delivered-byte counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_in  in  N  key value
- key_load  in  1  single-cycle strobe; loads key_in
- key_valid  out  1  a legal key is held
- key_err  out  1  last key_load was rejected (sticky until next key_load or rst)
- s_data  in  N  ciphertext byte
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts s_data this cycle
- m_data  out  N  plaintext byte
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts m_data
- byte_cnt  out  CNT_W  plaintext bytes delivered since the last rst or key_load

Behaviour:
- Reset (rst=1 at a clk edge):
  - key register = 0; key_valid = 0; key_err = 0; buffer emptied; m_valid = 0; byte_cnt = 0; m_data = 0.
  - Applies mid-stream too: all buffered bytes are discarded.
- Key states:
  - NOKEY → KEYED on a legal key_load.
  - A legal key_load while KEYED replaces the key and stays KEYED.
  - Only rst returns the block to NOKEY.
- Key legality:
  - ALPHA_MODE=0: any value is legal.
  - ALPHA_MODE=1: key_in ≥ 26 is illegal. The key is not loaded, key_err = 1, and key_valid and the key register are unchanged.
  - A legal load clears key_err.
  - Every key_load, legal or not, clears byte_cnt.
- Input acceptance:
  - A transfer occurs when s_valid & s_ready.
  - s_ready = key_valid & (fill < 2). It is a function of registers only.
- Decryption is computed combinationally at acceptance using the key held before any same-cycle key_load. Bytes already buffered keep their old-key result.
- Arithmetic:
  - Mode 0: (s_data − key) mod 2^N, computed N bits wide with the borrow discarded.
  - Mode 1, for 'A'..'Z' (0x41–0x5A): off = c − base; r = off − key; add 26 if r < 0; result = base + r. Same for 'a'..'z' (0x61–0x7A). All other bytes are unchanged.
- Output buffer:
  - 2-entry FIFO; m_data and m_valid come from the head register.
  - Latency: a byte accepted at edge t is visible on m_data/m_valid after edge t (one cycle).
  - Push and pop in the same cycle leaves fill unchanged, giving full throughput of 1 byte/cycle with m_ready held at 1.
- Output handshake rules:
  - m_valid, once asserted, stays high and m_data stays stable until m_valid & m_ready.
  - Order is preserved; no byte is dropped or duplicated.
  - Full (fill=2): s_ready = 0. Empty: m_valid = 0.
- byte_cnt:
  - Increments on each m_valid & m_ready and wraps modulo 2^CNT_W.
  - A key_load in the same cycle as a pop clears the counter (clear wins).

Decomposition:
- Package caesar_pkg holds:
  - ALPHA_LEN = 26
  - constants UPPER_A = 0x41, UPPER_Z = 0x5A, LOWER_A = 0x61, LOWER_Z = 0x7A
  - a function for the shared shift arithmetic, so the encryptor can reuse it.
- One sub-module: caesar_sub_core, purely combinational (data, key → plaintext) and selected by ALPHA_MODE.
- The FIFO and control logic stay in the top module.

Test Plan:
- Basic decrypt: rst; key_load key=3, ALPHA_MODE=0; send 0x4B, 0x68 with m_ready=1 → m_data 0x48, 0x65, each one cycle after acceptance; byte_cnt=2.
- Wrap-around: mode 0, key=0x05, input 0x01 → 0xFC; key=0xFF, input 0x00 → 0x01.
- Alpha mode: key=3; input 'b'(0x62) → 'y'(0x79), 'D'(0x44) → 'A'(0x41), '!'(0x21) → 0x21. key=1, 'A' → 'Z'(0x5A).
- Illegal key: alpha mode, key_load 26 → key_err=1, key_valid and previous key unchanged. Then key_load 25 → key_err=0, 'Z' → 'A'.
- Back-pressure: m_ready=0, s_valid=1 for three bytes 0x10, 0x11, 0x12 with key=1 → s_ready drops after two accepts. Raise m_ready → outputs 0x0F, 0x10, 0x11 in order, and m_data is stable while stalled.
- Key change and reset mid-stream:
  - key_load 7 in the same cycle as accepting 0x20 (old key 1) → output 0x1F; the next input 0x20 → 0x19.
  - Assert rst with 2 bytes buffered → next cycle m_valid=0, s_ready=0, key_valid=0, byte_cnt=0.
